// File: rtl/fifo_stream_reader.sv
// Drains the audio sample FIFO into a valid/ready stream through a 3-entry prefetch
// buffer that hides the FIFO's one-cycle read latency; also counts stream underruns.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [1:0]            buf_level,
  output logic                  underrun,
  output logic [CNT_WIDTH-1:0]  underrun_cnt
);

  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic                  armed_q, armed_d;
  logic [CNT_WIDTH-1:0]  ucnt_q, ucnt_d;
  logic                  pop, arrive, credit;
  logic [2:0]            occupancy;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Credit counts the word already requested, so the buffer can never overflow.
  assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q};
  assign credit     = (occupancy < 3'd3);
  assign fifo_rd_en = !rst_a && !fifo_empty && !flush && credit;

  assign m_valid      = (count_q != 2'd0);
  assign m_data       = buf_q[head_q];
  assign buf_level    = count_q;
  assign underrun     = armed_q && m_ready && !m_valid;
  assign underrun_cnt = ucnt_q;

  // A flush cycle reports no pop and drops the arriving word.
  assign pop    = m_valid && m_ready && !flush;
  assign arrive = inflight_q && !flush;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = fifo_rd_en;
    armed_d    = armed_q || pop;
    ucnt_d     = underrun ? sat_inc(ucnt_q) : ucnt_q;
    if (flush) begin
      head_d     = 2'd0;
      tail_d     = 2'd0;
      count_d    = 2'd0;
      inflight_d = 1'b0;
      armed_d    = 1'b0;
    end else begin
      if (arrive) tail_d = ptr_inc(tail_q);
      if (pop)    head_d = ptr_inc(head_q);
      if (arrive && !pop)      count_d = count_q + 2'd1;
      else if (!arrive && pop) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      armed_q    <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      armed_q    <= armed_d;
      ucnt_q     <= ucnt_d;
    end
  end

  // Storage is cleared on reset so m_data reads zero while rst_a is high.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else if (arrive) begin
      buf_q[tail_q] <= fifo_data;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO that has one-cycle read latency.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_a, fifo_empty, flush, m_ready, force_empty;
  logic [15:0] fifo_data;
  logic        fifo_rd_en, m_valid, underrun;
  logic [15:0] m_data;
  logic [1:0]  buf_level;
  logic [15:0] ucnt;
  logic        fifo_rd_en_s, m_valid_s, underrun_s;
  logic [15:0] m_data_s;
  logic [1:0]  buf_level_s;
  logic [3:0]  ucnt_s;

  logic [15:0] fq[$];
  logic [15:0] sb[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_a(rst_a), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .flush(flush), .buf_level(buf_level), .underrun(underrun), .underrun_cnt(ucnt)
  );

  fifo_stream_reader #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_a(rst_a), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en_s), .m_data(m_data_s), .m_valid(m_valid_s), .m_ready(m_ready),
    .flush(flush), .buf_level(buf_level_s), .underrun(underrun_s), .underrun_cnt(ucnt_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = force_empty || (fq.size() == 0);
  endtask

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    sb.push_back(w);
    upd_empty();
  endtask

  // Called at the negedge: latch the strobe, cross the posedge, present read data.
  task automatic next_cycle();
    logic rd;
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd && fq.size() != 0) fifo_data = fq.pop_front();
    upd_empty();
  endtask

  initial begin
    int strobes, viol_empty, viol_credit, delivered, seq, prev_rd;
    logic [15:0] exp_w;
    rst_a = 1'b1; flush = 1'b0; m_ready = 1'b1; force_empty = 1'b0; fifo_data = '0;
    for (int i = 1; i <= 8; i++) push(16'(i));
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_vld",   m_valid, 0);
    check_eq("rst_data",  m_data, 0);
    check_eq("rst_level", buf_level, 0);
    check_eq("rst_urun",  underrun, 0);
    check_eq("rst_cnt",   ucnt, 0);
    check_eq("rst_rd",    fifo_rd_en, 0);
    next_cycle();
    rst_a = 1'b0;

    // Startup through FIFO exhaustion and counter saturation
    for (int c = 0; c <= 34; c++) begin
      @(negedge clk);
      check_eq("st_rd",   fifo_rd_en, (c <= 7));
      check_eq("st_vld",  m_valid, (c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) check_eq("st_data", m_data, c - 1);
      check_eq("st_urun", underrun, (c >= 10));
      check_eq("sat_urun", underrun_s, (c >= 10));
      check_eq("st_cnt",  ucnt, (c > 10) ? c - 10 : 0);
      check_eq("sat_cnt", ucnt_s, (c > 10) ? ((c - 10 > 15) ? 15 : c - 10) : 0);
      next_cycle();
    end

    // Flush with a read in flight
    m_ready = 1'b0;
    push(16'h0200);
    push(16'h0201);
    @(negedge clk);
    check_eq("fl_rd0", fifo_rd_en, 1);
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check_eq("fl_rd1", fifo_rd_en, 0);
    next_cycle();
    flush = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check_eq("fl_level", buf_level, 0);
    check_eq("fl_vld",   m_valid, 0);
    check_eq("fl_noarm", underrun, 0);
    check_eq("fl_rd2",   fifo_rd_en, 1);
    next_cycle();
    @(negedge clk);
    check_eq("fl_noarm2", underrun, 0);
    next_cycle();
    @(negedge clk);
    check_eq("fl_vld2", m_valid, 1);
    check_eq("fl_data", m_data, 16'h0201);
    check_eq("fl_cnt",  ucnt, 25);
    next_cycle();
    m_ready = 1'b0;
    @(negedge clk);
    check_eq("fl_empty", m_valid, 0);
    check_eq("fl_cnt2",  ucnt, 25);
    check_eq("fl_sat",   ucnt_s, 15);
    next_cycle();

    // Backpressure
    for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fifo_rd_en) strobes++;
      if (m_valid) check_eq("bp_hold", m_data, 16'h0100);
      next_cycle();
    end
    @(negedge clk);
    check_eq("bp_strobes", strobes, 3);
    check_eq("bp_level", buf_level, 3);
    check_eq("bp_data",  m_data, 16'h0100);
    next_cycle();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_vld",  m_valid, 1);
      check_eq("bp_seq",  m_data, 16'h0100 + 16'(i));
      next_cycle();
    end
    m_ready = 1'b0;
    @(negedge clk);
    check_eq("bp_drained", buf_level, 0);
    check_eq("bp_cnt", ucnt, 25);
    next_cycle();

    // Asynchronous reset mid-stream
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(16'h0300 + 16'(i));
    @(negedge clk); next_cycle();
    @(negedge clk); next_cycle();
    @(negedge clk);
    check_eq("ar_pre", m_data, 16'h0300);
    next_cycle();
    rst_a = 1'b1;
    #1;
    check_eq("ar_vld",   m_valid, 0);
    check_eq("ar_data",  m_data, 0);
    check_eq("ar_level", buf_level, 0);
    check_eq("ar_cnt",   ucnt, 0);
    check_eq("ar_sat",   ucnt_s, 0);
    check_eq("ar_urun",  underrun, 0);
    check_eq("ar_rd",    fifo_rd_en, 0);
    @(negedge clk);
    next_cycle();
    rst_a = 1'b0;
    @(negedge clk);
    check_eq("ar_rd_rel", fifo_rd_en, 1);
    next_cycle();
    @(negedge clk);
    check_eq("ar_noarm", underrun, 0);
    next_cycle();
    @(negedge clk);
    check_eq("ar_d0", m_data, 16'h0303);
    next_cycle();
    @(negedge clk);
    check_eq("ar_d1", m_data, 16'h0304);
    next_cycle();
    @(negedge clk);
    check_eq("ar_urun2", underrun, 1);
    next_cycle();
    m_ready = 1'b0;
    @(negedge clk);
    next_cycle();

    // Random stress against the scoreboard
    sb.delete();
    viol_empty = 0; viol_credit = 0; delivered = 0; seq = 16'h1000; prev_rd = 0;
    for (int i = 0; i < 10000; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      force_empty = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1 && fq.size() < 8) begin
        push(16'(seq));
        seq++;
      end
      upd_empty();
      @(negedge clk);
      if (fifo_rd_en && fifo_empty) viol_empty++;
      if (int'(buf_level) + prev_rd > 3) viol_credit++;
      if (m_valid && m_ready) begin
        check_eq("rs_sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          check_eq("rs_data", m_data, exp_w);
        end
        delivered++;
      end
      prev_rd = int'(fifo_rd_en);
      next_cycle();
    end
    force_empty = 1'b0;
    m_ready = 1'b1;
    upd_empty();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      if (m_valid) begin
        exp_w = sb.pop_front();
        check_eq("rs_drain_data", m_data, exp_w);
        delivered++;
      end
      next_cycle();
    end
    check_eq("rs_drain", sb.size(), 0);
    check_eq("rs_count", delivered, seq - 16'h1000);
    check_eq("rs_rd_while_empty", viol_empty, 0);
    check_eq("rs_credit", viol_credit, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side companion for the audio sample FIFO. It drains the FIFO through its `rd_en`/`empty`/`data_out` port and presents the samples as a valid/ready stream to downstream effect and output stages. It hides the FIFO's one-cycle read latency behind a 3-entry prefetch buffer, so the stream sustains one sample per clock. It also counts underruns for audio-glitch diagnostics.

## Interface
Parameters:
- `DATA_WIDTH`, 16: sample width; must match the FIFO's data width.
- `CNT_WIDTH`, 16: width of the underrun counter.

Ports:
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst_a`  in  1: reset, asynchronous, active-high.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_data`  in  DATA_WIDTH: FIFO read data; valid in the cycle after `fifo_rd_en` was high.
- `fifo_rd_en`  out  1: FIFO read strobe; combinational from internal state and `fifo_empty`.
- `m_data`  out  DATA_WIDTH: stream data, i.e. the buffer head.
- `m_valid`  out  1: stream data valid.
- `m_ready`  in  1: downstream accepts.
- `flush`  in  1: synchronous discard of buffered and in-flight data.
- `buf_level`  out  2: buffer occupancy, 0..3.
- `underrun`  out  1: one-cycle pulse on each counted underrun cycle.
- `underrun_cnt`  out  CNT_WIDTH: saturating underrun count.

## Operation
- **State:**
  - 3-entry circular buffer with head/tail pointers (wrap 2→0).
  - `count` (0..3).
  - `inflight` (1 bit): a FIFO read was issued last cycle.
  - `armed` (1 bit).
- **Pop:** `m_valid && m_ready`. `m_valid = (count != 0)`. `m_data` = entry at the head.
- **Read issue:** `fifo_rd_en = !fifo_empty && !flush && (count + inflight < 3)`.
  - There is no path from `m_ready` to `fifo_rd_en`.
  - The block never strobes `fifo_rd_en` while `fifo_empty` is high.
- **Arrival:** if `inflight` is set and `flush` is low, `fifo_data` is written at the tail and the tail advances.
- **Update:** next `count = count + arrival − pop`. Next `inflight = fifo_rd_en`.
- **Overflow:** none. The credit rule guarantees `count + inflight ≤ 3`.
- **Flush (synchronous, one cycle):**
  - Clears `count`, pointers, `inflight` and `armed`.
  - The word arriving in the flush cycle is discarded.
  - No pop is reported to downstream during the flush cycle (`m_valid` still reflects the pre-flush state, but the buffer is cleared regardless).
  - `underrun_cnt` is not cleared.
- **Underrun accounting:**
  - `armed` sets on the first pop after reset or flush.
  - An underrun cycle is `armed && m_ready && !m_valid`.
  - Each underrun cycle pulses `underrun` and increments `underrun_cnt`.
  - The counter saturates at all-ones.
- **Simultaneous arrival and pop with `count = 0`:** not possible, since `m_valid = 0` means no pop. The arriving word becomes `m_data` on the next cycle.
- **Data ordering:** strict FIFO order; no reordering or duplication.

## Timing
- **Reset values** (all outputs while `rst_a` is high):
  - `m_valid = 0`, `m_data = 0`, `buf_level = 0`.
  - `underrun = 0`, `underrun_cnt = 0`.
  - `fifo_rd_en = 0`: forced, even if `fifo_empty = 0`.
  - Internal state: `count`, `inflight` and `armed` cleared.
- **Reset mid-operation:** any in-flight FIFO word is lost. After release, the first read may issue in the same cycle.
- **Latency:** `fifo_rd_en` high in cycle N → word captured at the end of N+1 → `m_valid` high in N+2. Two cycles from read strobe to stream valid.
- **Throughput:**
  - Steady state with `m_ready = 1` and a non-empty FIFO: one word per cycle, with `count` holding at 1 and `inflight = 1`.
  - With `m_ready = 0`: reads stop once `count + inflight = 3`, so at most 3 words are held.
- **Stream rule:** `m_data` and `m_valid` are stable while `m_valid && !m_ready`.
- **`buf_level`:** equals the registered `count`.
- **`underrun`:** combinational from registered state and `m_ready`. `underrun_cnt` updates on the edge ending the underrun cycle.

## Test plan
- **Startup:** FIFO preloaded with 0x0001..0x0008, `m_ready = 1` from reset release.
  - `fifo_rd_en` high in cycles 0..7, `m_valid` first high in cycle 2.
  - Data 0x0001..0x0008 appears on 8 consecutive cycles.
  - `underrun_cnt` stays 0 until the FIFO runs dry, then increments once per cycle.
- **Backpressure:** `m_ready = 0` with FIFO holding 10 words.
  - Exactly 3 `fifo_rd_en` strobes, then `buf_level = 3`.
  - `m_data` held at the first word.
  - Releasing `m_ready` resumes in-order output with no gaps.
- **Random stress:** random `m_ready` and random `fifo_empty` toggling over 10k cycles.
  - Scoreboard confirms in-order, lossless delivery.
  - `fifo_rd_en` is never high while `fifo_empty` is high.
  - `count + inflight ≤ 3` at all times.
- **Flush with a read in flight:** `flush` pulsed the cycle after a read.
  - The arriving word is dropped and `buf_level` is 0 next cycle.
  - The next delivered word is the FIFO's following entry.
  - `underrun_cnt` is unchanged.
- **Counter saturation:** with `CNT_WIDTH = 4`, hold `m_ready = 1` with an empty FIFO for 20 cycles after arming.
  - `underrun_cnt` saturates at 15.
  - `underrun` pulses every cycle.
- **Async reset mid-stream:** assert `rst_a` mid-stream.
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - Operation restarts cleanly after release.
